pim_cmd_sequencer: RTL and testbench



---
 rtl/pim_cmd_sequencer_if.sv | 22 ++
 rtl/pim_cmd_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pim_cmd_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pim_cmd_sequencer_if.sv
// Command and input-word handshake bundle between the peripheral bus master
// and pim_cmd_sequencer.
interface pim_cmd_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_mode;
   logic [6:0]  cmd_row_addr7;
   logic [8:0]  cmd_col_addr9;
   logic        data_valid;
   logic [31:0] data;
   logic        data_ready;

   modport master (
      output cmd_valid, cmd_mode, cmd_row_addr7, cmd_col_addr9, data_valid, data,
      input  cmd_ready, data_ready
   );

   modport slave (
      input  cmd_valid, cmd_mode, cmd_row_addr7, cmd_col_addr9, data_valid, data,
      output cmd_ready, data_ready
   );
endinterface

// File: rtl/pim_cmd_sequencer.sv
// PIM command sequencer: accepts one command, streams 16 MAC input words, then
// runs the execution phase. Optional abort input enabled by PIM_SEQ_ABORT_EN.
module pim_cmd_sequencer #(
   parameter int unsigned READ_CYCLES  = 4,
   parameter int unsigned PROG_CYCLES  = 12,
   parameter int unsigned ERASE_CYCLES = 16,
   parameter int unsigned MAC_CYCLES   = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
`ifdef PIM_SEQ_ABORT_EN
   input  logic                abort_i,
`endif
   pim_cmd_sequencer_if.slave  bus,
   output logic                pim_en_o,
   output logic [2:0]          pim_mode_o,
   output logic [3:0]          exec_cnt_o,
   output logic [6:0]          row_addr7_o,
   output logic [8:0]          col_addr9_o,
   output logic [31:0]         input_data_o,
   output logic [3:0]          data_rx_cnt_o,
   output logic                in_buf_write_o,
   output logic                in_buf_read_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_EXEC, S_DONE} state_e;

   localparam logic [2:0] MODE_READ  = 3'd1;
   localparam logic [2:0] MODE_PROG  = 3'd2;
   localparam logic [2:0] MODE_ERASE = 3'd3;
   localparam logic [2:0] MODE_MAC   = 3'd4;

   localparam logic [3:0] READ_LAST  = 4'(READ_CYCLES - 1);
   localparam logic [3:0] PROG_LAST  = 4'(PROG_CYCLES - 1);
   localparam logic [3:0] ERASE_LAST = 4'(ERASE_CYCLES - 1);
   localparam logic [3:0] MAC_LAST   = 4'(MAC_CYCLES - 1);

   state_e      state_q, state_d;
   logic [2:0]  mode_q, mode_d;
   logic [6:0]  row_q, row_d;
   logic [8:0]  col_q, col_d;
   logic [3:0]  k_q, k_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        wr_q, wr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wslot_q, wslot_d;
   logic [3:0]  exec_last;
   logic        abort_req;

`ifdef PIM_SEQ_ABORT_EN
   assign abort_req = abort_i &&
                      (state_q == S_LOAD || state_q == S_FLUSH || state_q == S_EXEC);
`else
   assign abort_req = 1'b0;
`endif

   always_comb begin
      case (mode_q)
         MODE_READ:  exec_last = READ_LAST;
         MODE_PROG:  exec_last = PROG_LAST;
         MODE_ERASE: exec_last = ERASE_LAST;
         default:    exec_last = MAC_LAST;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         mode_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         wslot_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         row_q   <= row_d;
         col_q   <= col_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         wslot_q <= wslot_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      row_d   = row_q;
      col_d   = col_q;
      k_d     = k_q;
      cnt_d   = '0;
      err_d   = err_q;
      wr_d    = 1'b0;
      wdata_d = wdata_q;
      wslot_d = wslot_q;

      case (state_q)
         S_IDLE: begin
            k_d = '0;
            if (bus.cmd_valid) begin
               mode_d = bus.cmd_mode;
               row_d  = bus.cmd_row_addr7;
               col_d  = bus.cmd_col_addr9;
               err_d  = 1'b0;
               case (bus.cmd_mode)
                  MODE_MAC:                        state_d = S_LOAD;
                  MODE_READ, MODE_PROG, MODE_ERASE: state_d = S_EXEC;
                  default: begin
                     state_d = S_DONE;
                     err_d   = 1'b1;
                  end
               endcase
            end
         end
         S_LOAD: begin
            // Write strobe and slot are registered so they appear one cycle after the handshake.
            if (bus.data_valid) begin
               wr_d    = 1'b1;
               wdata_d = bus.data;
               wslot_d = k_q;
               k_d     = k_q + 4'd1;
               if (k_q == 4'd15) state_d = S_FLUSH;
            end
         end
         S_FLUSH: state_d = S_EXEC;
         S_EXEC: begin
            if (cnt_q == exec_last) state_d = S_DONE;
            else                    cnt_d   = cnt_q + 4'd1;
         end
         S_DONE: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort_req) begin
         state_d = S_DONE;
         err_d   = 1'b1;
         wr_d    = 1'b0;
         cnt_d   = '0;
      end
   end

   assign bus.cmd_ready  = (state_q == S_IDLE);
   assign bus.data_ready = (state_q == S_LOAD);

   assign pim_en_o       = (state_q == S_EXEC);
   assign pim_mode_o     = mode_q;
   assign exec_cnt_o     = cnt_q;
   assign row_addr7_o    = row_q;
   assign col_addr9_o    = col_q;
   assign input_data_o   = wdata_q;
   assign data_rx_cnt_o  = wslot_q;
   assign in_buf_write_o = wr_q;
   assign in_buf_read_o  = (state_q == S_EXEC) && (mode_q == MODE_MAC) && (cnt_q == 4'd0);
   assign busy_o         = (state_q != S_IDLE);
   assign done_o         = (state_q == S_DONE);
   assign err_o          = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_pim_cmd_sequencer.sv
// Directed self-checking bench for pim_cmd_sequencer; abort scenario included
// when PIM_SEQ_ABORT_EN is defined.
module tb_pim_cmd_sequencer;
   logic        clk;
   logic        rst_n;
   logic        pim_en, in_buf_write, in_buf_read, busy, done, err;
   logic [2:0]  pim_mode;
   logic [3:0]  exec_cnt, data_rx_cnt;
   logic [6:0]  row_addr7;
   logic [8:0]  col_addr9;
   logic [31:0] input_data;
   int unsigned total  = 0;
   int unsigned passed = 0;
   int unsigned fails  = 0;
`ifdef PIM_SEQ_ABORT_EN
   logic        abort;
`endif

   pim_cmd_sequencer_if bus ();

   pim_cmd_sequencer dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
`ifdef PIM_SEQ_ABORT_EN
      .abort_i        (abort),
`endif
      .bus            (bus.slave),
      .pim_en_o       (pim_en),
      .pim_mode_o     (pim_mode),
      .exec_cnt_o     (exec_cnt),
      .row_addr7_o    (row_addr7),
      .col_addr9_o    (col_addr9),
      .input_data_o   (input_data),
      .data_rx_cnt_o  (data_rx_cnt),
      .in_buf_write_o (in_buf_write),
      .in_buf_read_o  (in_buf_read),
      .busy_o         (busy),
      .done_o         (done),
      .err_o          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_pim_en"}, pim_en, 0);
      chk({tag, "_mode"}, pim_mode, 0);
      chk({tag, "_exec_cnt"}, exec_cnt, 0);
      chk({tag, "_row"}, row_addr7, 0);
      chk({tag, "_col"}, col_addr9, 0);
      chk({tag, "_in_data"}, input_data, 0);
      chk({tag, "_rx_cnt"}, data_rx_cnt, 0);
      chk({tag, "_wr"}, in_buf_write, 0);
      chk({tag, "_rd"}, in_buf_read, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_data_ready"}, bus.data_ready, 0);
      chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
   endtask

   // Presents a command for exactly one cycle; returns in the first cycle after acceptance.
   task automatic send_cmd(input logic [2:0] mode, input logic [6:0] row, input logic [8:0] col);
      chk("cmd_ready_before_cmd", bus.cmd_ready, 1);
      bus.cmd_valid     = 1'b1;
      bus.cmd_mode      = mode;
      bus.cmd_row_addr7 = row;
      bus.cmd_col_addr9 = col;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_mode   = '0;
      bus.cmd_row_addr7 = '0;
      bus.cmd_col_addr9 = '0;
      bus.data_valid = 1'b0;
      bus.data       = '0;
`ifdef PIM_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      #1;
      chk_cleared("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // READ: 4 EXEC cycles, addresses held, single done without err
      send_cmd(3'd1, 7'h15, 9'h1A3);
      for (int i = 0; i < 4; i++) begin
         chk("read_pim_en", pim_en, 1);
         chk("read_exec_cnt", exec_cnt, i);
         chk("read_row", row_addr7, 7'h15);
         chk("read_col", col_addr9, 9'h1A3);
         chk("read_mode", pim_mode, 3'd1);
         chk("read_done_early", done, 0);
         chk("read_cmd_ready_busy", bus.cmd_ready, 0);
         tick();
      end
      chk("read_done", done, 1);
      chk("read_err", err, 0);
      chk("read_pim_en_off", pim_en, 0);
      chk("read_done_row", row_addr7, 7'h15);
      tick();
      chk("read_done_once", done, 0);
      chk("read_idle_ready", bus.cmd_ready, 1);
      chk("read_idle_busy", busy, 0);
      chk("read_idle_row_kept", row_addr7, 7'h15);

      // MAC, no stalls: command at T, done at T+26
      send_cmd(3'd4, 7'h7F, 9'h1FF);
      for (int i = 0; i < 16; i++) begin
         chk("mac_data_ready", bus.data_ready, 1);
         chk("mac_pim_en_load", pim_en, 0);
         chk("mac_wr", in_buf_write, i > 0);
         if (i > 0) begin
            chk("mac_rx_cnt", data_rx_cnt, i - 1);
            chk("mac_in_data", input_data, i - 1);
         end
         bus.data_valid = 1'b1;
         bus.data       = 32'(i);
         tick();
      end
      bus.data_valid = 1'b0;
      chk("mac_flush_data_ready", bus.data_ready, 0);
      chk("mac_flush_wr", in_buf_write, 1);
      chk("mac_flush_rx_cnt", data_rx_cnt, 15);
      chk("mac_flush_data", input_data, 15);
      chk("mac_flush_pim_en", pim_en, 0);
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("mac_exec_pim_en", pim_en, 1);
         chk("mac_exec_cnt", exec_cnt, i);
         chk("mac_rd", in_buf_read, i == 0);
         chk("mac_exec_wr", in_buf_write, 0);
         chk("mac_exec_row", row_addr7, 7'h7F);
         tick();
      end
      chk("mac_done_T26", done, 1);
      chk("mac_err", err, 0);
      tick();

      // MAC with a 3-cycle input stall after word 7
      send_cmd(3'd4, 7'h01, 9'h002);
      for (int i = 0; i < 16; i++) begin
         if (i == 8) begin
            bus.data_valid = 1'b0;
            for (int g = 0; g < 3; g++) begin
               chk("stall_wr", in_buf_write, g == 0);
               chk("stall_data_ready", bus.data_ready, 1);
               if (g == 0) chk("stall_rx_cnt", data_rx_cnt, 7);
               tick();
            end
            chk("stall_resume_wr", in_buf_write, 0);
         end else if (i > 0) begin
            chk("stall_seq_wr", in_buf_write, 1);
            chk("stall_seq_rx_cnt", data_rx_cnt, i - 1);
            chk("stall_seq_data", input_data, 32'hA500_0000 + 32'(i - 1));
         end
         bus.data_valid = 1'b1;
         bus.data       = 32'hA500_0000 + 32'(i);
         tick();
      end
      bus.data_valid = 1'b0;
      chk("stall_flush_rx_cnt", data_rx_cnt, 15);
      chk("stall_flush_data", input_data, 32'hA500_000F);
      chk("stall_flush_pim_en", pim_en, 0);
      tick();
      chk("stall_exec_start", pim_en, 1);
      chk("stall_exec_rd", in_buf_read, 1);
      for (int i = 0; i < 8; i++) tick();
      chk("stall_done", done, 1);
      tick();

      // Illegal mode 6, then ERASE
      send_cmd(3'd6, 7'h33, 9'h044);
      chk("illegal_done", done, 1);
      chk("illegal_err", err, 1);
      chk("illegal_pim_en", pim_en, 0);
      tick();
      chk("illegal_idle_done", done, 0);
      chk("illegal_idle_pim_en", pim_en, 0);
      chk("illegal_idle_ready", bus.cmd_ready, 1);
      send_cmd(3'd3, 7'h40, 9'h100);
      for (int i = 0; i < 16; i++) begin
         chk("erase_pim_en", pim_en, 1);
         chk("erase_exec_cnt", exec_cnt, i);
         chk("erase_rd", in_buf_read, 0);
         tick();
      end
      chk("erase_done", done, 1);
      chk("erase_err", err, 0);
      tick();

      // PROGRAM aborted by reset during EXEC cycle 5
      send_cmd(3'd2, 7'h2A, 9'h0F0);
      for (int i = 0; i < 5; i++) tick();
      chk("prog_exec_cnt5", exec_cnt, 5);
      chk("prog_pim_en", pim_en, 1);
      rst_n = 1'b0;
      #1;
      chk_cleared("prog_rst");
      tick();
      chk("prog_rst_no_done", done, 0);
      rst_n = 1'b1;
      send_cmd(3'd1, 7'h0C, 9'h0D0);
      chk("post_rst_pim_en", pim_en, 1);
      chk("post_rst_mode", pim_mode, 3'd1);
      chk("post_rst_row", row_addr7, 7'h0C);
      for (int i = 0; i < 4; i++) tick();
      chk("post_rst_done", done, 1);
      tick();

`ifdef PIM_SEQ_ABORT_EN
      // Abort in LOAD after word 4
      send_cmd(3'd4, 7'h11, 9'h022);
      for (int i = 0; i < 5; i++) begin
         bus.data_valid = 1'b1;
         bus.data       = 32'h5A00_0000 + 32'(i);
         tick();
      end
      bus.data_valid = 1'b0;
      chk("abort_wr_word4", in_buf_write, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_done", done, 1);
      chk("abort_err", err, 1);
      chk("abort_pim_en", pim_en, 0);
      chk("abort_wr", in_buf_write, 0);
      chk("abort_rd", in_buf_read, 0);
      tick();
      chk("abort_idle", busy, 0);
      chk("abort_idle_pim_en", pim_en, 0);
      chk("abort_idle_ready", bus.cmd_ready, 1);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
